// File: rtl/qpi_pkg.sv
// Shared defaults and FSM encoding for the QPI register-file arbiter.
package qpi_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam logic [ADDR_W_DEF-1:0] RO_BASE_DEF = 8'hF0;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HOST_WR = 3'd2,
    ST_HOST_RD = 3'd3,
    ST_INT_ACC = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_spram.sv
// Single-port synchronous RAM, 1-cycle read latency, write-first on collision.
module regfile_spram
  import qpi_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array, kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register; a write returns the new data on the same port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (we) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/qpi_regfile_arbiter.sv
// Serializes host and internal accesses onto one single-port register RAM.
module qpi_regfile_arbiter
  import qpi_pkg::*;
#(
  parameter int unsigned       ADDR_W         = ADDR_W_DEF,
  parameter int unsigned       DATA_W         = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RO_BASE        = ADDR_W'(RO_BASE_DEF),
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              main_clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_data_flag,
  input  logic              read_data_flag,
  output logic [DATA_W-1:0] read_data,
  output logic              host_wr_blocked,
  output logic              cfg_changed,
  output logic [ADDR_W-1:0] cfg_addr,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  output logic              int_gnt,
  output logic [DATA_W-1:0] int_rdata,
  output logic              int_rvalid,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] INIT_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_wr_pend;
  logic              host_rd_pend;
  logic              wr_pend_nxt;
  logic              rd_pend_nxt;
  logic              accept;
  logic              host_ro;
  logic              host_rd_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  assign host_ro   = (host_addr >= RO_BASE);
  assign int_rdata = ram_rdata;

  regfile_spram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (main_clock),
    .rst   (reset),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // State register; reset restarts the clear sweep (or goes idle if disabled).
  always_ff @(posedge main_clock) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // RAM port drive for the current access plus priority arbitration of the next one.
  always_comb begin
    state_nxt = ST_IDLE;
    ram_we    = 1'b0;
    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    accept    = (state != ST_INIT);

    // Pending work after this cycle: un-serviced flags plus newly sampled ones.
    wr_pend_nxt = (host_wr_pend && (state != ST_HOST_WR)) || (write_data_flag && accept);
    rd_pend_nxt = (host_rd_pend && (state != ST_HOST_RD)) || (read_data_flag && accept);

    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = init_cnt;
        ram_wdata = '0;
      end
      ST_HOST_WR: begin
        ram_we = !host_ro;
      end
      ST_INT_ACC: begin
        ram_we    = int_we;
        ram_addr  = int_addr;
        ram_wdata = int_wdata;
      end
      default: begin
      end
    endcase

    // A reset in the same cycle aborts the access in flight.
    if (reset) begin
      ram_we = 1'b0;
    end

    // The request being granted this cycle must not be granted again.
    if ((state == ST_INIT) && (init_cnt != INIT_LAST)) begin
      state_nxt = ST_INIT;
    end else if (wr_pend_nxt) begin
      state_nxt = ST_HOST_WR;
    end else if (rd_pend_nxt) begin
      state_nxt = ST_HOST_RD;
    end else if (int_req && (state != ST_INT_ACC)) begin
      state_nxt = ST_INT_ACC;
    end else begin
      state_nxt = ST_IDLE;
    end
  end

  // Clear-sweep address counter.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + ADDR_W'(1);
    end
  end

  // Host request capture: pending flags with their address and data.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      host_wr_pend <= 1'b0;
      host_rd_pend <= 1'b0;
      host_addr    <= '0;
      host_wdata   <= '0;
    end else begin
      host_wr_pend <= wr_pend_nxt;
      host_rd_pend <= rd_pend_nxt;
      if (accept && (write_data_flag || read_data_flag)) begin
        host_addr  <= addr;
        host_wdata <= write_data;
      end
    end
  end

  // Registered status pulses, host read data and internal handshake.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      init_done       <= !CLEAR_ON_RESET;
      cfg_changed     <= 1'b0;
      host_wr_blocked <= 1'b0;
      cfg_addr        <= '0;
      int_gnt         <= 1'b0;
      int_rvalid      <= 1'b0;
      host_rd_q       <= 1'b0;
      read_data       <= '0;
    end else begin
      if ((state == ST_INIT) && (init_cnt == INIT_LAST)) begin
        init_done <= 1'b1;
      end
      cfg_changed     <= (state == ST_HOST_WR) && !host_ro;
      host_wr_blocked <= (state == ST_HOST_WR) && host_ro;
      if ((state == ST_HOST_WR) && !host_ro) begin
        cfg_addr <= host_addr;
      end
      int_gnt    <= (state_nxt == ST_INT_ACC);
      int_rvalid <= (state == ST_INT_ACC) && !int_we;
      host_rd_q  <= (state == ST_HOST_RD);
      if (host_rd_q) begin
        read_data <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_qpi_regfile_arbiter.sv
// Self-checking bench for qpi_regfile_arbiter against a memory-array model.
module tb_qpi_regfile_arbiter;

  logic       main_clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr = '0;
  logic [7:0] write_data = '0;
  logic       write_data_flag = 1'b0;
  logic       read_data_flag = 1'b0;
  logic [7:0] read_data;
  logic       host_wr_blocked;
  logic       cfg_changed;
  logic [7:0] cfg_addr;
  logic       int_req = 1'b0;
  logic       int_we = 1'b0;
  logic [7:0] int_addr = '0;
  logic [7:0] int_wdata = '0;
  logic       int_gnt;
  logic [7:0] int_rdata;
  logic       int_rvalid;
  logic       init_done;

  always #5 main_clock = ~main_clock;

  qpi_regfile_arbiter dut (
    .main_clock      (main_clock),
    .reset           (reset),
    .addr            (addr),
    .write_data      (write_data),
    .write_data_flag (write_data_flag),
    .read_data_flag  (read_data_flag),
    .read_data       (read_data),
    .host_wr_blocked (host_wr_blocked),
    .cfg_changed     (cfg_changed),
    .cfg_addr        (cfg_addr),
    .int_req         (int_req),
    .int_we          (int_we),
    .int_addr        (int_addr),
    .int_wdata       (int_wdata),
    .int_gnt         (int_gnt),
    .int_rdata       (int_rdata),
    .int_rvalid      (int_rvalid),
    .init_done       (init_done)
  );

  int vectors = 0;
  int errors = 0;

  // Reference register file and the value the host last read back.
  logic [7:0] model [256];
  logic [7:0] prev_rd = '0;

  // Observations of one transaction window (cycle numbers, -1 = never seen).
  int         obs_gnt, obs_rv, obs_cfg, obs_blk;
  logic [7:0] obs_rvd, obs_cfga;
  logic [7:0] obs_rd [9];

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // Host write first, then host read, then the internal access.
  task automatic model_step(input bit hw, input bit hr, input logic [7:0] ha, input logic [7:0] hd,
                            input bit ir, input bit iwe, input logic [7:0] ia, input logic [7:0] id,
                            output logic [7:0] e_h, output logic [7:0] e_i);
    e_h = 8'h00;
    e_i = 8'h00;
    if (hw && (ha < 8'hF0)) model[ha] = hd;
    if (hr) e_h = model[ha];
    if (ir) begin
      if (iwe) model[ia] = id;
      else e_i = model[ia];
    end
  endtask

  // Drive one transaction at cycle 0 and record outputs over cycles 1..8.
  task automatic run_txn(input bit hw, input bit hr, input logic [7:0] ha, input logic [7:0] hd,
                         input bit ir, input bit iwe, input logic [7:0] ia, input logic [7:0] id);
    obs_gnt = -1; obs_rv = -1; obs_cfg = -1; obs_blk = -1;
    obs_rvd = '0; obs_cfga = '0;
    addr = ha; write_data = hd; write_data_flag = hw; read_data_flag = hr;
    int_req = ir; int_we = iwe; int_addr = ia; int_wdata = id;
    obs_rd[0] = read_data;
    for (int c = 1; c <= 8; c++) begin
      @(negedge main_clock);
      write_data_flag = 1'b0;
      read_data_flag = 1'b0;
      if (int_gnt && (obs_gnt < 0)) obs_gnt = c;
      if (int_rvalid && (obs_rv < 0)) begin obs_rv = c; obs_rvd = int_rdata; end
      if (cfg_changed && (obs_cfg < 0)) begin obs_cfg = c; obs_cfga = cfg_addr; end
      if (host_wr_blocked && (obs_blk < 0)) obs_blk = c;
      obs_rd[c] = read_data;
      if ((obs_gnt >= 0) && (c == obs_gnt + 1)) int_req = 1'b0;
    end
    int_req = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    int bad;
    int g;
    reset = 1'b1;
    repeat (2) @(negedge main_clock);
    vectors++;
    if ({read_data, int_rdata, cfg_addr} !== 24'h0) begin
      errors++; $display("FAIL rst_data: got %h/%h/%h, expected 00/00/00", read_data, int_rdata, cfg_addr);
    end
    vectors++;
    if ({init_done, int_gnt, int_rvalid, cfg_changed, host_wr_blocked} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b, expected 00000",
                         {init_done, int_gnt, int_rvalid, cfg_changed, host_wr_blocked});
    end
    reset = 1'b0;
    int_req = 1'b1; int_we = 1'b0; int_addr = 8'h37;
    cnt = 0; bad = 0;
    while (!init_done && (cnt < 400)) begin
      if (cnt == 10) begin addr = 8'h37; read_data_flag = 1'b1; end
      if (cnt == 11) read_data_flag = 1'b0;
      @(negedge main_clock);
      cnt++;
      if (int_gnt && !init_done) bad++;
    end
    vectors++;
    if (cnt !== 256) begin errors++; $display("FAIL init_cycles: got %0d, expected 256", cnt); end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL gnt_in_init: got %0d grants, expected 0", bad); end
    g = 0;
    while (!int_gnt && (g < 8)) begin @(negedge main_clock); g++; end
    vectors++;
    if (int_gnt !== 1'b1) begin errors++; $display("FAIL init_int_gnt: got %b, expected 1", int_gnt); end
    @(negedge main_clock);
    int_req = 1'b0;
    vectors++;
    if ({int_rvalid, int_rdata} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL init_rd37: got rvalid=%b data=%h, expected 1/00", int_rvalid, int_rdata);
    end
    vectors++;
    if (read_data !== 8'h00) begin errors++; $display("FAIL init_host_rd: got %h, expected 00", read_data); end
    model_clear();
    prev_rd = 8'h00;
    repeat (2) @(negedge main_clock);
  endtask

  task automatic test_host_write_read();
    logic [7:0] eh, ei;
    model_step(1, 0, 8'hAB, 8'hCD, 0, 0, 8'h00, 8'h00, eh, ei);
    run_txn(1, 0, 8'hAB, 8'hCD, 0, 0, 8'h00, 8'h00);
    vectors++;
    if (obs_cfg !== 2) begin errors++; $display("FAIL hw_cfg_cycle: got %0d, expected 2", obs_cfg); end
    vectors++;
    if (obs_cfga !== 8'hAB) begin errors++; $display("FAIL hw_cfg_addr: got %h, expected ab", obs_cfga); end
    vectors++;
    if (obs_blk !== -1) begin errors++; $display("FAIL hw_blocked: got %0d, expected -1", obs_blk); end
    model_step(0, 1, 8'hAB, 8'h00, 0, 0, 8'h00, 8'h00, eh, ei);
    run_txn(0, 1, 8'hAB, 8'h00, 0, 0, 8'h00, 8'h00);
    vectors++;
    if (obs_rd[2] !== prev_rd) begin errors++; $display("FAIL hr_early: got %h, expected %h", obs_rd[2], prev_rd); end
    vectors++;
    if (obs_rd[3] !== 8'hCD) begin errors++; $display("FAIL hr_data: got %h, expected cd", obs_rd[3]); end
    vectors++;
    if (obs_cfg !== -1) begin errors++; $display("FAIL hr_no_cfg: got %0d, expected -1", obs_cfg); end
    prev_rd = 8'hCD;
  endtask

  task automatic test_int_vs_host();
    logic [7:0] eh, ei;
    model_step(1, 0, 8'h10, 8'h53, 1, 0, 8'hAB, 8'h00, eh, ei);
    run_txn(1, 0, 8'h10, 8'h53, 1, 0, 8'hAB, 8'h00);
    vectors++;
    if (obs_gnt !== 2) begin errors++; $display("FAIL ivh_gnt_cycle: got %0d, expected 2", obs_gnt); end
    vectors++;
    if (obs_rv !== 3) begin errors++; $display("FAIL ivh_rvalid_cycle: got %0d, expected 3", obs_rv); end
    vectors++;
    if (obs_rvd !== 8'hCD) begin errors++; $display("FAIL ivh_rdata: got %h, expected cd", obs_rvd); end
    vectors++;
    if ((obs_cfg !== 2) || (obs_cfga !== 8'h10)) begin
      errors++; $display("FAIL ivh_cfg: got cycle %0d addr %h, expected 2/10", obs_cfg, obs_cfga);
    end
  endtask

  task automatic test_ro_region();
    logic [7:0] eh, ei;
    model_step(0, 0, 8'h00, 8'h00, 1, 1, 8'hF4, 8'h99, eh, ei);
    run_txn(0, 0, 8'h00, 8'h00, 1, 1, 8'hF4, 8'h99);
    vectors++;
    if ((obs_gnt !== 1) || (obs_rv !== -1)) begin
      errors++; $display("FAIL ro_int_wr: got gnt %0d rvalid %0d, expected 1/-1", obs_gnt, obs_rv);
    end
    model_step(1, 0, 8'hF4, 8'h11, 0, 0, 8'h00, 8'h00, eh, ei);
    run_txn(1, 0, 8'hF4, 8'h11, 0, 0, 8'h00, 8'h00);
    vectors++;
    if (obs_blk !== 2) begin errors++; $display("FAIL ro_blocked: got %0d, expected 2", obs_blk); end
    vectors++;
    if (obs_cfg !== -1) begin errors++; $display("FAIL ro_no_cfg: got %0d, expected -1", obs_cfg); end
    vectors++;
    if (cfg_addr !== 8'h10) begin errors++; $display("FAIL ro_cfg_hold: got %h, expected 10", cfg_addr); end
    model_step(0, 1, 8'hF4, 8'h00, 0, 0, 8'h00, 8'h00, eh, ei);
    run_txn(0, 1, 8'hF4, 8'h00, 0, 0, 8'h00, 8'h00);
    vectors++;
    if (obs_rd[3] !== 8'h99) begin errors++; $display("FAIL ro_readback: got %h, expected 99", obs_rd[3]); end
    prev_rd = 8'h99;
  endtask

  task automatic test_wr_rd_same();
    logic [7:0] eh, ei;
    model_step(1, 1, 8'h20, 8'h5A, 0, 0, 8'h00, 8'h00, eh, ei);
    run_txn(1, 1, 8'h20, 8'h5A, 0, 0, 8'h00, 8'h00);
    vectors++;
    if (obs_rd[3] !== prev_rd) begin errors++; $display("FAIL wr_rd_early: got %h, expected %h", obs_rd[3], prev_rd); end
    vectors++;
    if (obs_rd[4] !== 8'h5A) begin errors++; $display("FAIL wr_rd_data: got %h, expected 5a", obs_rd[4]); end
    vectors++;
    if (obs_rd[8] !== 8'h5A) begin errors++; $display("FAIL wr_rd_hold: got %h, expected 5a", obs_rd[8]); end
    prev_rd = 8'h5A;
  endtask

  task automatic test_random();
    bit hw, hr, ir, iwe;
    logic [7:0] ha, hd, ia, id, eh, ei;
    int exp_gnt, exp_cfg, exp_blk;
    for (int n = 0; n < 48; n++) begin
      hw = 1'($urandom_range(0, 1));
      hr = 1'($urandom_range(0, 1));
      ir = 1'($urandom_range(0, 1));
      iwe = 1'($urandom_range(0, 1));
      ha = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom_range(0, 31));
      ia = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom_range(0, 31));
      hd = 8'($urandom);
      id = 8'($urandom);
      model_step(hw, hr, ha, hd, ir, iwe, ia, id, eh, ei);
      run_txn(hw, hr, ha, hd, ir, iwe, ia, id);
      exp_gnt = ir ? (1 + int'(hw) + int'(hr)) : -1;
      exp_cfg = (hw && (ha < 8'hF0)) ? 2 : -1;
      exp_blk = (hw && (ha >= 8'hF0)) ? 2 : -1;
      vectors++;
      if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd%0d_gnt: got %0d, expected %0d", n, obs_gnt, exp_gnt); end
      vectors++;
      if (obs_cfg !== exp_cfg) begin errors++; $display("FAIL rnd%0d_cfg: got %0d, expected %0d", n, obs_cfg, exp_cfg); end
      vectors++;
      if (obs_blk !== exp_blk) begin errors++; $display("FAIL rnd%0d_blk: got %0d, expected %0d", n, obs_blk, exp_blk); end
      if (exp_cfg == 2) begin
        vectors++;
        if (obs_cfga !== ha) begin errors++; $display("FAIL rnd%0d_cfga: got %h, expected %h", n, obs_cfga, ha); end
      end
      if (ir && !iwe) begin
        vectors++;
        if ((obs_rv !== exp_gnt + 1) || (obs_rvd !== ei)) begin
          errors++; $display("FAIL rnd%0d_irдва: got cycle %0d data %h, expected %0d/%h", n, obs_rv, obs_rvd, exp_gnt + 1, ei);
        end
      end else begin
        vectors++;
        if (obs_rv !== -1) begin errors++; $display("FAIL rnd%0d_no_rvalid: got %0d, expected -1", n, obs_rv); end
      end
      if (hr) begin
        vectors++;
        if ((obs_rd[2 + int'(hw)] !== prev_rd) || (obs_rd[3 + int'(hw)] !== eh)) begin
          errors++; $display("FAIL rnd%0d_hrd: got %h then %h, expected %h then %h",
                             n, obs_rd[2 + int'(hw)], obs_rd[3 + int'(hw)], prev_rd, eh);
        end
        prev_rd = eh;
      end else begin
        vectors++;
        if (obs_rd[8] !== prev_rd) begin errors++; $display("FAIL rnd%0d_hold: got %h, expected %h", n, obs_rd[8], prev_rd); end
      end
    end
  endtask

  task automatic test_reset_mid_init();
    int cnt;
    int bad;
    int g;
    run_txn(0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 8'hA5);
    run_txn(0, 0, 8'h00, 8'h00, 1, 1, 8'h37, 8'h77);
    reset = 1'b1;
    @(negedge main_clock);
    reset = 1'b0;
    cnt = 0; bad = 0;
    while (!init_done && (cnt < 600)) begin
      if (cnt == 50) begin int_req = 1'b1; int_we = 1'b0; int_addr = 8'hFF; end
      if (cnt == 100) reset = 1'b1;
      if (cnt == 101) reset = 1'b0;
      if (cnt == 200) begin addr = 8'h37; read_data_flag = 1'b1; end
      if (cnt == 201) read_data_flag = 1'b0;
      @(negedge main_clock);
      cnt++;
      if (int_gnt && !init_done) bad++;
    end
    vectors++;
    if (cnt !== 357) begin errors++; $display("FAIL reinit_cycles: got %0d, expected 357", cnt); end
    vectors++;
    if (bad !== 0) begin errors++; $display("FAIL reinit_gnt: got %0d grants, expected 0", bad); end
    g = 0;
    while (!int_gnt && (g < 8)) begin @(negedge main_clock); g++; end
    vectors++;
    if (int_gnt !== 1'b1) begin errors++; $display("FAIL reinit_int_gnt: got %b, expected 1", int_gnt); end
    @(negedge main_clock);
    int_req = 1'b0;
    vectors++;
    if ({int_rvalid, int_rdata} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL reinit_rdff: got rvalid=%b data=%h, expected 1/00", int_rvalid, int_rdata);
    end
    vectors++;
    if (read_data !== 8'h00) begin errors++; $display("FAIL reinit_host_rd: got %h, expected 00", read_data); end
    model_clear();
    prev_rd = 8'h00;
    repeat (2) @(negedge main_clock);
    run_txn(0, 1, 8'h37, 8'h00, 0, 0, 8'h00, 8'h00);
    vectors++;
    if (obs_rd[3] !== 8'h00) begin errors++; $display("FAIL reinit_rd37: got %h, expected 00", obs_rd[3]); end
  endtask

  initial begin
    test_reset();
    test_host_write_read();
    test_int_vs_host();
    test_ro_region();
    test_wr_rd_same();
    test_random();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
